line_buffer_writer: RTL and testbench
=====================================

Name: line_buffer_writer

Overview:
Downstream consumer of the Bresenham line stage. It captures the 64x64 one-bit line_buffer when the line stage signals done. It scans the bitmap row by row and issues one frame-buffer pixel write per set bit, offset by a screen origin and coloured with a latched colour. It sits between the BLA wrapper and the frame-buffer/SRAM arbiter.

Parameters:
GRID_DIM, 64, side length of the square line bitmap (buffer width GRID_DIM*GRID_DIM)
FB_WIDTH, 640, frame-buffer width in pixels (row stride)
FB_HEIGHT, 480, frame-buffer height in pixels
ADDR_W, 19, frame-buffer pixel address width
COLOR_W, 24, pixel colour width

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  job request, driven by the line stage's bla_done; rising edge accepted
line_buffer  in  4096  bitmap; bit index = row*64 + col; 1 = pixel on
x_off  in  10  screen x of bitmap column 0
y_off  in  9  screen y of bitmap row 0
color  in  COLOR_W  pixel colour for this job
wr_valid  out  1  pixel write request
wr_addr  out  ADDR_W  pixel address = (y_off+row)*FB_WIDTH + (x_off+col)
wr_data  out  COLOR_W  latched colour
wr_ready  in  1  frame-buffer accepts the write at the posedge where wr_valid&wr_ready
busy  out  1  high from job accept until done
wb_done  out  1  one-cycle pulse when the job completes
px_count  out  13  writes issued in the last or current job

Behaviour:
- Reset (async, any state): state IDLE; wr_valid, busy, wb_done = 0; wr_addr, wr_data, px_count = 0; edge register = 0. wr_valid falls immediately, without waiting for a clock.
- Start detect: start_q registers start. A job is accepted only in IDLE, on start & ~start_q. If start is held high, there is no retrigger. Edges while busy are ignored.
- Accept (IDLE): latch line_buffer, x_off, y_off, color. Set row = col = 0 and px_count = 0. Next state SCAN, busy = 1 from the next cycle.
- SCAN, 1 cycle per step:
  - If col == 0 and the whole latched row is zero, skip the row (row+1).
  - Otherwise test bit (row,col). If it is set and on-screen (x_off+col < FB_WIDTH and y_off+row < FB_HEIGHT), go to WRITE and load wr_addr and wr_data.
  - Otherwise advance: col+1; when col = 63, go to col 0 and row+1.
  - Advancing past row 63, col 63 goes to DONE.
- WRITE: wr_valid = 1, with wr_addr and wr_data held stable until accepted.
  - On a posedge with wr_ready = 1: px_count+1, wr_valid = 0 next cycle, advance the position as in SCAN, then return to SCAN or DONE.
  - With wr_ready = 0: hold indefinitely.
- DONE: wb_done = 1 and busy = 0 for exactly one cycle, then IDLE. px_count holds until the next accept.
- Arithmetic:
  - Screen coordinates are computed unsigned at 11 bits to prevent wrap.
  - Off-screen pixels are skipped silently and are not counted.
  - The address is truncated to ADDR_W only after the clip check.
- Latency: from accept to the first wr_valid is 1 + (skipped rows) + (pixels scanned) cycles. An empty buffer gives wb_done 66 cycles after the accepting edge (1 accept + 64 row skips + 1).
- New line_buffer and color values during a job have no effect.

Test Plan:
- Reset: assert n_rst=0 mid-simulation -> wr_valid, busy, wb_done, px_count = 0 asynchronously; state IDLE.
- Empty buffer: line_buffer=0, start rising -> no wr_valid; wb_done pulses once, 66 cycles after accept; px_count=0.
- Single pixel: bit row 2 col 5, x_off=10, y_off=20, color=24'hFF0000, wr_ready=1 -> exactly one write with wr_addr=14095 and wr_data=24'hFF0000; px_count=1.
- Diagonal (0,0)..(23,23) with wr_ready held low 3 cycles on the first write -> wr_addr=0 held stable for 4 cycles; 24 writes at addresses k*641; px_count=24.
- Clipping: x_off=620, bits at row 0 cols 10 and 30 -> only col 10 is written (addr 630); px_count=1.
- Retrigger/abort:
  - start held high after wb_done -> no second job.
  - Drop and re-raise start -> new job runs.
  - n_rst pulse during WRITE -> wr_valid drops immediately, and the next start runs a clean job.

Source files
------------

// File: rtl/line_buffer_writer.sv
// line_buffer_writer
//
// Takes the 64x64 one-bit bitmap from the Bresenham line stage and turns every
// set bit into one frame-buffer pixel write. The bitmap, screen origin and colour
// are captured when a job is accepted. The captured bitmap is then scanned row by
// row. Each step tests one cell, except that an all-zero row is skipped in a
// single step.
//
// Ports:
//   clk, n_rst     system clock (rising edge), asynchronous active-low reset
//   start          job request (rising edge accepted while idle)
//   line_buffer    bitmap, bit index = row*GRID_DIM + col, 1 = pixel on
//   x_off, y_off   screen position of bitmap cell (0,0)
//   color          colour applied to every pixel of the job
//   wr_valid/wr_ready/wr_addr/wr_data   pixel write handshake to the arbiter
//   busy           job in progress
//   wb_done        one-cycle completion pulse
//   px_count       pixels written in the current or most recent job
module line_buffer_writer #(
    parameter int GRID_DIM  = 64,
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int COLOR_W   = 24
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         start,
    input  logic [GRID_DIM*GRID_DIM-1:0] line_buffer,
    input  logic [9:0]                   x_off,
    input  logic [8:0]                   y_off,
    input  logic [COLOR_W-1:0]           color,
    output logic                         wr_valid,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [COLOR_W-1:0]           wr_data,
    input  logic                         wr_ready,
    output logic                         busy,
    output logic                         wb_done,
    output logic [12:0]                  px_count
);

    localparam int IDX_W = $clog2(GRID_DIM);
    localparam int CELLS = GRID_DIM * GRID_DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_DIM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic [CELLS-1:0]     bitmap_q, bitmap_d;
    logic [9:0]           x_off_q, x_off_d;
    logic [8:0]           y_off_q, y_off_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [IDX_W-1:0]     row_q, row_d;
    logic [IDX_W-1:0]     col_q, col_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]   wr_data_q, wr_data_d;
    logic [12:0]          px_count_q, px_count_d;

    logic [GRID_DIM-1:0]  row_bits;
    logic                 cur_bit;
    logic [10:0]          scr_x;
    logic [10:0]          scr_y;
    logic                 on_screen;
    logic                 accept;
    logic                 skip_row;
    logic                 hit;
    logic                 last_row;
    logic                 at_end;

    // Decisions shared by the next-state and datapath logic. Screen coordinates
    // are 11 bits wide, so x_off+col and y_off+row cannot wrap before the clip test.
    always_comb begin
        row_bits  = bitmap_q[{row_q, {IDX_W{1'b0}}} +: GRID_DIM];
        cur_bit   = bitmap_q[{row_q, col_q}];
        scr_x     = 11'(x_off_q) + 11'(col_q);
        scr_y     = 11'(y_off_q) + 11'(row_q);
        on_screen = (scr_x < 11'(FB_WIDTH)) && (scr_y < 11'(FB_HEIGHT));
        accept    = start && !start_q;
        skip_row  = (col_q == '0) && (row_bits == '0);
        hit       = cur_bit && on_screen;
        last_row  = (row_q == LAST_IDX);
        at_end    = last_row && (col_q == LAST_IDX);
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            bitmap_q   <= '0;
            x_off_q    <= '0;
            y_off_q    <= '0;
            color_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            px_count_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            bitmap_q   <= bitmap_d;
            x_off_q    <= x_off_d;
            y_off_q    <= y_off_d;
            color_q    <= color_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            px_count_q <= px_count_d;
        end
    end

    // Next-state logic. A skipped final row, or an advance past the last cell,
    // ends the job.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SCAN;
            end
            SCAN: begin
                if (skip_row) begin
                    if (last_row) state_d = DONE;
                end else if (hit) begin
                    state_d = WRITE;
                end else if (at_end) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (wr_ready) state_d = at_end ? DONE : SCAN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates. The scan position moves forward after a cell that is not
    // written, and after a write has been accepted. The address is truncated to
    // ADDR_W only after the pixel has passed the clip test.
    always_comb begin
        start_d    = start;
        bitmap_d   = bitmap_q;
        x_off_d    = x_off_q;
        y_off_d    = y_off_q;
        color_d    = color_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        px_count_d = px_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bitmap_d   = line_buffer;
                    x_off_d    = x_off;
                    y_off_d    = y_off;
                    color_d    = color;
                    row_d      = '0;
                    col_d      = '0;
                    px_count_d = '0;
                end
            end
            SCAN: begin
                if (skip_row) begin
                    row_d = row_q + IDX_W'(1);
                end else if (hit) begin
                    wr_addr_d = ADDR_W'(22'(scr_y) * 22'(FB_WIDTH) + 22'(scr_x));
                    wr_data_d = color_q;
                end else if (col_q == LAST_IDX) begin
                    col_d = '0;
                    row_d = row_q + IDX_W'(1);
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    px_count_d = px_count_q + 13'd1;
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the state. wr_valid therefore drops as soon as
    // reset forces the state back to IDLE, without waiting for a clock edge.
    always_comb begin
        wr_valid = (state_q == WRITE);
        busy     = (state_q == SCAN) || (state_q == WRITE);
        wb_done  = (state_q == DONE);
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
        px_count = px_count_q;
    end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Testbench for line_buffer_writer. A table of bitmap jobs covers the clip
// boundaries, hand sequences cover latency, backpressure, retrigger and abort,
// and random jobs are compared against a plain per-cell reference model.
`timescale 1ns/1ps
module tb_line_buffer_writer;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [4095:0] line_buffer;
    logic [9:0]    x_off;
    logic [8:0]    y_off;
    logic [23:0]   color;
    logic          wr_valid;
    logic [18:0]   wr_addr;
    logic [23:0]   wr_data;
    logic          wr_ready;
    logic          busy;
    logic          wb_done;
    logic [12:0]   px_count;

    line_buffer_writer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .line_buffer (line_buffer),
        .x_off       (x_off),
        .y_off       (y_off),
        .color       (color),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .wb_done     (wb_done),
        .px_count    (px_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [4095:0] bm;
        logic [9:0]    xo;
        logic [8:0]    yo;
        logic [23:0]   col;
        int            exp_count;
        int            exp_first;
    } vec_t;

    vec_t          vecs[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    int unsigned   cap_addr[$];
    logic [23:0]   cap_data[$];
    logic [4095:0] job_bm;
    logic [9:0]    job_x;
    logic [8:0]    job_y;
    logic [23:0]   job_col;
    logic [4095:0] rbm;
    int            ready_mode;
    int            hold_left;
    int            cyc;
    int            done_at;
    int            first_hold;
    int            unstable;
    int            busy_first;
    int            busy_at_done;
    int            extra_done;
    int            seen;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [4095:0] px(input int r, input int c);
        logic [4095:0] v;
        v = '0;
        v[r*64 + c] = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input logic [4095:0] bm, input logic [9:0] xo,
                                 input logic [8:0] yo, input logic [23:0] col);
        line_buffer = bm;
        x_off = xo;
        y_off = yo;
        color = col;
        job_bm = bm;
        job_x = xo;
        job_y = yo;
        job_col = col;
    endtask

    // One clock: choose wr_ready, log an accepted handshake, and step to the next negedge.
    task automatic tick();
        logic          pv;
        logic          pacc;
        logic [18:0]   pa;
        logic [23:0]   pd;
        case (ready_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (wr_valid && hold_left > 0) begin
                    wr_ready = 1'b0;
                    hold_left--;
                end else begin
                    wr_ready = 1'b1;
                end
            end
            default: wr_ready = 1'b0;
        endcase
        if (wr_valid && cap_addr.size() == 0) first_hold++;
        if (wr_valid && wr_ready) begin
            cap_addr.push_back(int'(wr_addr));
            cap_data.push_back(wr_data);
        end
        pv = wr_valid;
        pacc = wr_valid && wr_ready;
        pa = wr_addr;
        pd = wr_data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pv && !pacc && wr_valid && (wr_addr != pa || wr_data != pd)) unstable++;
    endtask

    // Cycle 1 is the cycle whose closing edge accepts the job. done_at is the number
    // of the cycle in which wb_done is high.
    task automatic runJob(input bit keep_start, input bit scramble);
        cap_addr.delete();
        cap_data.delete();
        cyc = 0;
        done_at = -1;
        first_hold = 0;
        unstable = 0;
        busy_first = 0;
        busy_at_done = 0;
        extra_done = 0;
        start = 1'b1;
        while (cyc < 20000 && done_at < 0) begin
            tick();
            if (cyc == 1) begin
                busy_first = int'(busy);
                if (scramble) begin
                    line_buffer = ~job_bm;
                    color = ~job_col;
                end
            end
            if (wb_done) begin
                done_at = cyc + 1;
                busy_at_done = int'(busy);
            end
        end
        checkOutput("job completes within budget", longint'(done_at > 0), 1);
        tick();
        extra_done = int'(wb_done);
        if (!keep_start) start = 1'b0;
    endtask

    // Reference: visit every cell in row-major order and emit the address of each
    // set cell that lands on the 640x480 screen.
    task automatic checkModel(input string name);
        int unsigned want[$];
        int n;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (job_bm[r*64 + c] && (int'(job_x) + c < 640) && (int'(job_y) + r < 480))
                    want.push_back(unsigned'((int'(job_y) + r) * 640 + int'(job_x) + c));
        checkOutput({name, " write count"}, cap_addr.size(), want.size());
        checkOutput({name, " px_count"}, px_count, want.size());
        n = (cap_addr.size() < want.size()) ? cap_addr.size() : want.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s addr[%0d]", name, i), cap_addr[i], want[i]);
            checkOutput($sformatf("%s data[%0d]", name, i), cap_data[i], job_col);
        end
        checkOutput({name, " addr/data stable while stalled"}, unstable, 0);
        checkOutput({name, " wb_done single pulse"}, extra_done, 0);
        checkOutput({name, " busy low at done"}, busy_at_done, 0);
    endtask

    function automatic vec_t mk(input string nm, input logic [4095:0] bm, input logic [9:0] xo,
                                input logic [8:0] yo, input logic [23:0] col, input int cnt,
                                input int first);
        vec_t v;
        v.name = nm; v.bm = bm; v.xo = xo; v.yo = yo; v.col = col;
        v.exp_count = cnt; v.exp_first = first;
        return v;
    endfunction

    initial begin
        n_rst = 1'b1;
        start = 1'b0;
        wr_ready = 1'b0;
        ready_mode = 0;
        hold_left = 0;
        applyStimulus('0, '0, '0, '0);

        // Reset state
        #2 n_rst = 1'b0;
        #1;
        checkOutput("reset wr_valid", wr_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset wb_done", wb_done, 0);
        checkOutput("reset px_count", px_count, 0);
        checkOutput("reset wr_addr", wr_addr, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Boundary table
        vecs.push_back(mk("empty", '0, 10'd0, 9'd0, 24'h123456, 0, -1));
        vecs.push_back(mk("single", px(2, 5), 10'd10, 9'd20, 24'hFF0000, 1, 14095));
        vecs.push_back(mk("clip x", px(0, 10) | px(0, 30), 10'd620, 9'd0, 24'h00FF00, 1, 630));
        vecs.push_back(mk("corner", px(63, 63), 10'd0, 9'd0, 24'h0000FF, 1, 40383));
        vecs.push_back(mk("last pixel", px(63, 63), 10'd576, 9'd416, 24'hABCDEF, 1, 307199));
        vecs.push_back(mk("one past right", px(63, 63), 10'd577, 9'd416, 24'h111111, 0, -1));
        vecs.push_back(mk("clip y", px(5, 0) | px(15, 0), 10'd0, 9'd470, 24'h222222, 1, 304000));
        vecs.push_back(mk("all off", px(0, 0) | px(10, 10), 10'd1023, 9'd511, 24'h333333, 0, -1));
        vecs.push_back(mk("full row", {64{1'b1}} << (7*64), 10'd0, 9'd0, 24'h444444, 64, 4480));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].bm, vecs[i].xo, vecs[i].yo, vecs[i].col);
            ready_mode = 0;
            runJob(1'b0, 1'b0);
            tick();
            checkOutput({vecs[i].name, " count"}, px_count, vecs[i].exp_count);
            checkOutput({vecs[i].name, " busy after accept"}, busy_first, 1);
            if (vecs[i].exp_count > 0 && cap_addr.size() > 0)
                checkOutput({vecs[i].name, " first addr"}, cap_addr[0], vecs[i].exp_first);
            checkModel(vecs[i].name);
        end

        // Empty buffer: 1 accept cycle + 64 row skips, then wb_done in cycle 66
        applyStimulus('0, 10'd0, 9'd0, 24'h0);
        runJob(1'b0, 1'b0);
        checkOutput("empty done cycle", done_at, 66);
        checkOutput("empty no writes", cap_addr.size(), 0);
        checkOutput("empty px_count", px_count, 0);
        tick();

        // Diagonal with the first write stalled for 3 cycles
        rbm = '0;
        for (int k = 0; k < 24; k++) rbm = rbm | px(k, k);
        applyStimulus(rbm, 10'd0, 9'd0, 24'h00A0A0);
        ready_mode = 2;
        hold_left = 3;
        runJob(1'b0, 1'b0);
        checkOutput("diag first write held cycles", first_hold, 4);
        checkOutput("diag writes", cap_addr.size(), 24);
        for (int k = 0; k < 24 && k < cap_addr.size(); k++)
            checkOutput($sformatf("diag addr[%0d]", k), cap_addr[k], k * 641);
        checkOutput("diag px_count", px_count, 24);
        checkOutput("diag stable", unstable, 0);
        ready_mode = 0;
        tick();

        // start held high after completion must not launch a second job
        applyStimulus(px(1, 1), 10'd3, 9'd4, 24'h555555);
        runJob(1'b1, 1'b0);
        checkModel("held start job");
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy || wr_valid || wb_done) seen++;
        end
        checkOutput("no retrigger while start held", seen, 0);
        start = 1'b0;
        tick();
        applyStimulus(px(3, 9), 10'd100, 9'd50, 24'h666666);
        runJob(1'b0, 1'b0);
        checkModel("re-raised start job");
        tick();

        // Reset while a write is stalled
        applyStimulus(px(2, 5), 10'd10, 9'd20, 24'h00FF00);
        ready_mode = 3;
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 400 && !wr_valid; i++) tick();
        checkOutput("abort reaches write", wr_valid, 1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("abort wr_valid async", wr_valid, 0);
        checkOutput("abort busy async", busy, 0);
        checkOutput("abort wr_addr async", wr_addr, 0);
        checkOutput("abort wb_done", wb_done, 0);
        start = 1'b0;
        ready_mode = 0;
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        applyStimulus(px(2, 5) | px(40, 7), 10'd10, 9'd20, 24'h777777);
        runJob(1'b0, 1'b0);
        checkModel("after abort");
        tick();

        // Random jobs with random backpressure and inputs changed mid-job
        for (int j = 0; j < 8; j++) begin
            int n;
            rbm = '0;
            n = $urandom_range(0, 30);
            for (int p = 0; p < n; p++)
                rbm = rbm | px($urandom_range(0, 63), $urandom_range(0, 63));
            applyStimulus(rbm, 10'($urandom_range(0, 700)), 9'($urandom_range(0, 511)),
                          24'($urandom));
            ready_mode = 1;
            runJob(1'b0, 1'b1);
            checkModel($sformatf("random %0d", j));
            ready_mode = 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
